// File: rtl/axis_replay_pacer_if.sv
// AXI4-Stream bundle used on both sides of the replay pacer.
interface axis_replay_pacer_if #(
   parameter int unsigned DATA_WIDTH  = 256,
   parameter int unsigned TUSER_WIDTH = 128
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [TUSER_WIDTH-1:0]  tuser;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;

   modport master (output tdata, output tstrb, output tuser, output tvalid, output tlast,
                   input tready);
   modport slave  (input tdata, input tstrb, input tuser, input tvalid, input tlast,
                   output tready);
endinterface

// File: rtl/axis_replay_pacer.sv
// Paces AXIS packet starts by a per-packet delay taken from TUSER, then forwards the packet
// through a two-entry register slice. AXIS_REPLAY_PACER_STATS_EN adds pkt_cnt/wait_cycles.
module axis_replay_pacer #(
   parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned DELAY_LSB            = 96
) (
   input  logic                 axi_aclk,
   input  logic                 axi_aresetn,
   input  logic                 sw_rst,
   input  logic                 pace_en,
   axis_replay_pacer_if.slave   s_axis,
   axis_replay_pacer_if.master  m_axis
`ifdef AXIS_REPLAY_PACER_STATS_EN
   ,
   output logic [31:0]          pkt_cnt,
   output logic [31:0]          wait_cycles
`endif
);

   localparam int unsigned StrbWidth = C_M_AXIS_DATA_WIDTH / 8;
   localparam int unsigned PayWidth  = C_M_AXIS_DATA_WIDTH + StrbWidth + C_M_AXIS_TUSER_WIDTH + 1;

   typedef enum logic {StSop, StBody} state_e;

   state_e              state_q, state_d;
   logic [31:0]         gap_cnt_q, gap_cnt_d;
   logic [31:0]         delay;
   logic [1:0]          count_q, count_d;
   logic                not_full_q;
   logic [PayWidth-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic [PayWidth-1:0] pay_in;
   logic                sop_ok, push, pop, sop_push;

   assign delay  = pace_en ? s_axis.tuser[DELAY_LSB +: 32] : 32'd0;
   assign sop_ok = (state_q == StBody) || (gap_cnt_q >= delay);
   // sw_rst gates ready directly so no beat is handshaken while the block is being cleared
   assign s_axis.tready = not_full_q && !sw_rst && sop_ok;

   assign push     = s_axis.tvalid && s_axis.tready;
   assign pop      = m_axis.tvalid && m_axis.tready;
   assign sop_push = push && (state_q == StSop);
   assign pay_in   = {s_axis.tdata, s_axis.tstrb, s_axis.tuser, s_axis.tlast};

   assign m_axis.tvalid = (count_q != 2'd0);
   assign {m_axis.tdata, m_axis.tstrb, m_axis.tuser, m_axis.tlast} = ent0_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StSop:   if (push && !s_axis.tlast) state_d = StBody;
         StBody:  if (push && s_axis.tlast)  state_d = StSop;
         default: state_d = StSop;
      endcase
   end

   always_comb begin
      gap_cnt_d = gap_cnt_q;
      if (sop_push) begin
         gap_cnt_d = 32'd1;
      end else if (gap_cnt_q != 32'hFFFF_FFFF) begin
         gap_cnt_d = gap_cnt_q + 32'd1;
      end
   end

   // ent0 is always the head; ent1 only holds a beat while count is 2
   always_comb begin
      count_d = count_q;
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      unique case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) ent0_d = pay_in;
            else                 ent1_d = pay_in;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               ent0_d = pay_in;
            end else begin
               ent0_d = ent1_q;
               ent1_d = pay_in;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q    <= StSop;
         gap_cnt_q  <= 32'hFFFF_FFFF;
         count_q    <= 2'd0;
         not_full_q <= 1'b0;
         ent0_q     <= '0;
         ent1_q     <= '0;
      end else if (sw_rst) begin
         state_q    <= StSop;
         gap_cnt_q  <= 32'hFFFF_FFFF;
         count_q    <= 2'd0;
         not_full_q <= 1'b0;
         ent0_q     <= '0;
         ent1_q     <= '0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         count_q    <= count_d;
         not_full_q <= (count_d != 2'd2);
         ent0_q     <= ent0_d;
         ent1_q     <= ent1_d;
      end
   end

`ifdef AXIS_REPLAY_PACER_STATS_EN
   logic [31:0] pkt_cnt_q, wait_q;
   logic        wait_cond;

   assign wait_cond   = (state_q == StSop) && s_axis.tvalid && (gap_cnt_q < delay);
   assign pkt_cnt     = pkt_cnt_q;
   assign wait_cycles = wait_q;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         pkt_cnt_q <= '0;
         wait_q    <= '0;
      end else if (sw_rst) begin
         pkt_cnt_q <= '0;
         wait_q    <= '0;
      end else begin
         if (push && s_axis.tlast) pkt_cnt_q <= pkt_cnt_q + 32'd1;
         if (wait_cond && (wait_q != 32'hFFFF_FFFF)) wait_q <= wait_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_replay_pacer.sv
// Directed and random bench for axis_replay_pacer with a queue-based beat scoreboard.
module tb_axis_replay_pacer;

   localparam int unsigned DW   = 256;
   localparam int unsigned UW   = 128;
   localparam int unsigned SW   = DW / 8;
   localparam int unsigned DLSB = 96;
   localparam int unsigned PW   = DW + SW + UW + 1;

   logic axi_aclk    = 1'b0;
   logic axi_aresetn = 1'b0;
   logic sw_rst      = 1'b0;
   logic pace_en     = 1'b1;

   axis_replay_pacer_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
   axis_replay_pacer_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

`ifdef AXIS_REPLAY_PACER_STATS_EN
   logic [31:0] pkt_cnt, wait_cycles;
`endif

   axis_replay_pacer #(
      .C_M_AXIS_DATA_WIDTH  (DW),
      .C_M_AXIS_TUSER_WIDTH (UW),
      .DELAY_LSB            (DLSB)
   ) dut (
      .axi_aclk    (axi_aclk),
      .axi_aresetn (axi_aresetn),
      .sw_rst      (sw_rst),
      .pace_en     (pace_en),
      .s_axis      (s_if),
      .m_axis      (m_if)
`ifdef AXIS_REPLAY_PACER_STATS_EN
      ,
      .pkt_cnt     (pkt_cnt),
      .wait_cycles (wait_cycles)
`endif
   );

   always #5 axi_aclk = ~axi_aclk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int stall_cycles = 0;
   int sop_cyc[$];
   int out_cyc[$];
   logic [PW-1:0] sb[$];
   bit            in_pkt     = 1'b0;
   bit            prev_stall = 1'b0;
   bit            rand_ready = 1'b0;
   logic [PW-1:0] prev_pay;
   logic [PW-1:0] exp_pay;
   logic [PW-1:0] s_pay, m_pay;

   assign s_pay = {s_if.tdata, s_if.tstrb, s_if.tuser, s_if.tlast};
   assign m_pay = {m_if.tdata, m_if.tstrb, m_if.tuser, m_if.tlast};

   always @(posedge axi_aclk) cyc++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Monitor: scoreboard push on input handshake, pop/compare on output handshake
   always @(negedge axi_aclk) begin
      if (sw_rst || !axi_aresetn) begin
         sb.delete();
         in_pkt     = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_checks++;
            assert (m_if.tvalid === 1'b1 && m_pay === prev_pay) else begin
               n_errors++;
               $error("FAIL axis_stable: got valid=%b pay=%h expected valid=1 pay=%h",
                      m_if.tvalid, m_pay, prev_pay);
            end
         end
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_pay   = m_pay;
         if (s_if.tvalid && !s_if.tready) stall_cycles++;
         if (s_if.tvalid && s_if.tready) begin
            sb.push_back(s_pay);
            if (!in_pkt) sop_cyc.push_back(cyc);
            in_pkt = !s_if.tlast;
         end
         if (m_if.tvalid && m_if.tready) begin
            out_cyc.push_back(cyc);
            n_checks++;
            assert (sb.size() != 0) else begin
               n_errors++;
               $error("FAIL sb_extra_beat: got pay=%h expected no beat", m_pay);
            end
            if (sb.size() != 0) begin
               exp_pay = sb.pop_front();
               n_checks++;
               assert (m_pay === exp_pay) else begin
                  n_errors++;
                  $error("FAIL sb_beat: got %h expected %h", m_pay, exp_pay);
               end
            end
         end
      end
   end

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [UW-1:0] rnd_user(input logic [31:0] d);
      logic [UW-1:0] r;
      for (int i = 0; i < UW / 32; i++) r[i*32 +: 32] = $urandom;
      r[DLSB +: 32] = d;
      return r;
   endfunction

   task automatic step();
      @(posedge axi_aclk);
      #1;
      if (rand_ready) m_if.tready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_beat(input logic [UW-1:0] u, input logic last);
      bit hs = 1'b0;
      int n  = 0;
      s_if.tdata  = rnd_data();
      s_if.tstrb  = $urandom;
      s_if.tuser  = u;
      s_if.tlast  = last;
      s_if.tvalid = 1'b1;
      while (!hs && n < 3000) begin
         @(negedge axi_aclk);
         hs = s_if.tvalid && s_if.tready;
         step();
         n++;
      end
      s_if.tvalid = 1'b0;
      n_checks++;
      assert (hs) else begin
         n_errors++;
         $error("FAIL send_timeout: got no accept after %0d cycles expected accept", n);
      end
   endtask

   // Delay field is random on body beats: only the SOP beat's field may matter
   task automatic send_pkt(input int nbeats, input logic [31:0] d);
      for (int i = 0; i < nbeats; i++) begin
         send_beat(rnd_user((i == 0) ? d : $urandom), (i == nbeats - 1));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         step();
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic clear_logs();
      sop_cyc.delete();
      out_cyc.delete();
      stall_cycles = 0;
   endtask

   initial begin
      int start_cyc;
      int total_beats;
      int len;
`ifdef AXIS_REPLAY_PACER_STATS_EN
      logic [31:0] w0;
`endif
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tstrb  = '0;
      s_if.tuser  = '0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;

      // Reset state
      idle(3);
      chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("rst_m_tlast", 64'(m_if.tlast), 64'd0);
      chk("rst_m_tdata_or", 64'(|m_if.tdata), 64'd0);
      chk("rst_m_tuser_or", 64'(|m_if.tuser), 64'd0);
      chk("rst_s_tready", 64'(s_if.tready), 64'd0);
      axi_aresetn = 1'b1;
      idle(3);

      // 4-beat packet, D = 0, no backpressure
      clear_logs();
      send_pkt(4, 32'd0);
      drain();
      idle(2);
      chk("t1_out_beats", 64'(out_cyc.size()), 64'd4);
      chk("t1_latency", 64'(out_cyc[0] - sop_cyc[0]), 64'd1);
      chk("t1_contiguous", 64'(out_cyc[3] - out_cyc[0]), 64'd3);

      // Back-to-back 2-beat packets, second with D = 10, pacing on
      idle(5);
      clear_logs();
`ifdef AXIS_REPLAY_PACER_STATS_EN
      w0 = wait_cycles;
`endif
      send_pkt(2, 32'd0);
      send_pkt(2, 32'd10);
      drain();
      chk("t2_sop_gap", 64'(sop_cyc[1] - sop_cyc[0]), 64'd10);
      chk("t2_stalls", 64'(stall_cycles), 64'd8);
`ifdef AXIS_REPLAY_PACER_STATS_EN
      chk("t2_wait_cycles", 64'(wait_cycles - w0), 64'd8);
`endif

      // Same stimulus, pacing off
      idle(5);
      clear_logs();
      pace_en = 1'b0;
      send_pkt(2, 32'd0);
      send_pkt(2, 32'd10);
      drain();
      pace_en = 1'b1;
      chk("t3_sop_gap", 64'(sop_cyc[1] - sop_cyc[0]), 64'd2);
      chk("t3_stalls", 64'(stall_cycles), 64'd0);

      // Single-beat packets, D = 3, then D = 1 back-to-back
      idle(5);
      clear_logs();
      send_pkt(1, 32'd3);
      send_pkt(1, 32'd3);
      send_pkt(1, 32'd3);
      send_pkt(1, 32'd1);
      send_pkt(1, 32'd1);
      drain();
      chk("t5_gap_a", 64'(sop_cyc[1] - sop_cyc[0]), 64'd3);
      chk("t5_gap_b", 64'(sop_cyc[2] - sop_cyc[1]), 64'd3);
      chk("t5_gap_d1", 64'(sop_cyc[4] - sop_cyc[3]), 64'd1);
      chk("t5_stalls", 64'(stall_cycles), 64'd4);

      // sw_rst mid-packet with the slice full
      idle(3);
      m_if.tready = 1'b0;
      send_beat(rnd_user(32'd0), 1'b0);
      send_beat(rnd_user(32'd0), 1'b0);
      idle(1);
      chk("t6_full_valid", 64'(m_if.tvalid), 64'd1);
      chk("t6_full_ready", 64'(s_if.tready), 64'd0);
      sw_rst = 1'b1;
      chk("t6_swrst_ready", 64'(s_if.tready), 64'd0);
      @(posedge axi_aclk);
      #1;
      sw_rst = 1'b0;
      start_cyc = cyc;
      clear_logs();
      chk("t6_after_valid", 64'(m_if.tvalid), 64'd0);
      chk("t6_after_tlast", 64'(m_if.tlast), 64'd0);
      chk("t6_after_tuser_or", 64'(|m_if.tuser), 64'd0);
`ifdef AXIS_REPLAY_PACER_STATS_EN
      chk("t6_pkt_cnt_clr", 64'(pkt_cnt), 64'd0);
`endif
      m_if.tready = 1'b1;
      send_pkt(1, 32'd1000);
      drain();
      idle(2);
      chk("t6_no_wait", 64'(sop_cyc[0] - start_cyc), 64'd1);
      chk("t6_out_beats", 64'(out_cyc.size()), 64'd1);

      // 100 random packets with random output backpressure
      sw_rst = 1'b1;
      step();
      sw_rst = 1'b0;
      idle(2);
      clear_logs();
      total_beats = 0;
      rand_ready  = 1'b1;
      for (int p = 0; p < 100; p++) begin
         len = $urandom_range(1, 6);
         total_beats += len;
         send_pkt(len, 32'($urandom_range(0, 4)));
      end
      rand_ready  = 1'b0;
      m_if.tready = 1'b1;
      drain();
      idle(2);
      chk("t4_out_beats", 64'(out_cyc.size()), 64'(total_beats));
      chk("t4_sops", 64'(sop_cyc.size()), 64'd100);
`ifdef AXIS_REPLAY_PACER_STATS_EN
      chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd100);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
